serial_product_receiver: RTL and testbench

//  Receiving end of the serial product stream emitted by the shift-add multiplier.
//  - Sits beside the multiplier and shares its start strobe.
//  - Deserialises the LSB-first product bits into a 2N-bit word.
//  - Presents the word downstream with a valid/ready handshake.
//  - Flags overruns when the consumer is too slow.

---
 rtl/sam_pkg.sv | 32 +++
 rtl/serial_product_receiver_if.sv | 30 +++
 rtl/sipo_shift_reg.sv | 25 ++
 rtl/serial_product_receiver.sv | 113 +++++++++++
 tb/tb_serial_product_receiver.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sam_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sam_pkg
// Brief    : Shared types and helpers for the shift-add multiplier product path.
// Revision : 1.0
// ============================================================================
package sam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SKEW    = 2'd1,
        ST_COLLECT = 2'd2
    } state_t;

    localparam int unsigned N_DEFAULT = 32;
    localparam int unsigned PW        = 2 * N_DEFAULT;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned prod_width(input int unsigned n);
        return 2 * n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_product_receiver_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_product_receiver_if
// Brief    : Frame control, serial stream and product handshake bundle.
// Revision : 1.0
// ============================================================================
interface serial_product_receiver_if #(
    parameter int N = 32
);
    logic           start;
    logic           serial_in;
    logic [2*N-1:0] prod_data;
    logic           prod_valid;
    logic           prod_ready;
    logic           busy;
    logic           overrun;
    logic           overrun_clr;

    // master: the receiver producing words; slave: the consumer/stimulus side
    modport master (
        input  start, serial_in, prod_ready, overrun_clr,
        output prod_data, prod_valid, busy, overrun
    );

    modport slave (
        output start, serial_in, prod_ready, overrun_clr,
        input  prod_data, prod_valid, busy, overrun
    );
endinterface
`default_nettype wire

// File: rtl/sipo_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : sipo_shift_reg
// Brief    : Right-shifting SIPO register, serial input enters at the MSB.
// Revision : 1.0
// ============================================================================
module sipo_shift_reg #(
    parameter int W = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         clr,
    input  wire logic         shift_en,
    input  wire logic         serial_in,
    output logic [W-1:0]      q
);
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {serial_in, q[W-1:1]};
        end
    end
endmodule
`default_nettype wire

// File: rtl/serial_product_receiver.sv
`default_nettype none
// ============================================================================
// Module   : serial_product_receiver
// Brief    : Deserialises the LSB-first multiplier product and hands it off.
// Revision : 1.0
// ============================================================================
module serial_product_receiver
    import sam_pkg::*;
#(
    parameter int N    = 32,
    parameter int SKEW = 1
) (
    input  wire logic              clk,
    input  wire logic              rst,
    serial_product_receiver_if.master bus
);
    localparam int             PW_L      = int'(prod_width(N));
    localparam int             CW        = int'(clog2(PW_L));
    localparam logic [CW-1:0]  BIT_LAST  = CW'(PW_L - 1);
    localparam logic [1:0]     SKEW_LAST = (SKEW > 1) ? 2'(SKEW - 2) : 2'd0;
    localparam state_t         ST_FIRST  = (SKEW == 1) ? ST_COLLECT : ST_SKEW;

    state_t          r_state;
    state_t          w_state_next;
    logic [1:0]      r_skew_cnt;
    logic [CW-1:0]   r_bit_cnt;
    logic [PW_L-1:0] w_shreg;
    logic [PW_L-1:0] w_word;
    logic [PW_L-1:0] r_prod_data;
    logic            r_prod_valid;
    logic            r_overrun;
    logic            w_collect;
    logic            w_complete;
    logic            w_overrun_set;

    assign w_collect     = (r_state == ST_COLLECT);
    assign w_complete    = w_collect && (r_bit_cnt == BIT_LAST);
    // The final bit is still on serial_in at the completion edge
    assign w_word        = {bus.serial_in, w_shreg[PW_L-1:1]};
    assign w_overrun_set = w_complete && r_prod_valid && !bus.prod_ready;

    sipo_shift_reg #(.W(PW_L)) u_sipo (
        .clk       (clk),
        .rst       (rst),
        .clr       (bus.start),
        .shift_en  (w_collect),
        .serial_in (bus.serial_in),
        .q         (w_shreg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (bus.start) begin
            w_state_next = ST_FIRST;
        end else begin
            case (r_state)
                ST_SKEW:    if (r_skew_cnt == SKEW_LAST) w_state_next = ST_COLLECT;
                ST_COLLECT: if (r_bit_cnt == BIT_LAST)   w_state_next = ST_IDLE;
                default:    w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.start) begin
            r_skew_cnt <= 2'd0;
            r_bit_cnt  <= '0;
        end else begin
            if (r_state == ST_SKEW) begin
                r_skew_cnt <= r_skew_cnt + 2'd1;
            end
            if (w_collect) begin
                r_bit_cnt <= w_complete ? '0 : r_bit_cnt + CW'(1);
            end
        end
    end

    // A completion always wins over an accept on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prod_data  <= '0;
            r_prod_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_complete) begin
                r_prod_data  <= w_word;
                r_prod_valid <= 1'b1;
            end else if (r_prod_valid && bus.prod_ready) begin
                r_prod_valid <= 1'b0;
            end
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (bus.overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.prod_data  = r_prod_data;
    assign bus.prod_valid = r_prod_valid;
    assign bus.overrun    = r_overrun;
    assign bus.busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_serial_product_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_product_receiver
// Brief    : Directed bench for the serial product receiver (N=4 and N=32).
// Revision : 1.0
// ============================================================================
module tb_serial_product_receiver;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    serial_product_receiver_if #(.N(4))  b4  ();
    serial_product_receiver_if #(.N(32)) b32 ();

    serial_product_receiver #(.N(4), .SKEW(1)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (b4)
    );

    serial_product_receiver #(.N(32), .SKEW(2)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (b32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed4(input logic [7:0] w, input logic ready_last, input logic start_last);
        for (int i = 0; i < 8; i++) begin
            b4.serial_in = w[i];
            if (i == 7) begin
                b4.prod_ready = ready_last;
                b4.start      = start_last;
            end
            step();
        end
        b4.serial_in  = 1'b0;
        b4.prod_ready = 1'b0;
        b4.start      = 1'b0;
    endtask

    task automatic run4(input logic [7:0] w, input logic ready_last, input logic start_last);
        b4.start = 1'b1;
        step();
        b4.start = 1'b0;
        feed4(w, ready_last, start_last);
    endtask

    task automatic accept_and_clear();
        b4.prod_ready  = 1'b1;
        b4.overrun_clr = 1'b1;
        step();
        b4.prod_ready  = 1'b0;
        b4.overrun_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        b4.start = 0; b4.serial_in = 0; b4.prod_ready = 0; b4.overrun_clr = 0;
        b32.start = 0; b32.serial_in = 0; b32.prod_ready = 0; b32.overrun_clr = 0;
        step();
        step();
        rst = 1'b0;
        checks++; if (b4.prod_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", b4.prod_valid); end
        checks++; if (b4.prod_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", b4.prod_data); end
        checks++; if (b4.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", b4.busy); end
        checks++; if (b4.overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", b4.overrun); end
        checks++; if (b32.prod_valid !== 1'b0 || b32.busy !== 1'b0) begin failures++; $display("FAIL reset_n32 got=%b%b exp=00", b32.prod_valid, b32.busy); end
    endtask

    task automatic test_single();
        logic [7:0] w;
        w = 8'h8F;
        b4.start = 1'b1;
        step();
        b4.start = 1'b0;
        checks++; if (b4.busy !== 1'b1) begin failures++; $display("FAIL single_busy_after_start got=%b exp=1", b4.busy); end
        for (int i = 0; i < 8; i++) begin
            b4.serial_in = w[i];
            step();
            if (i == 6) begin
                checks++; if (b4.prod_valid !== 1'b0) begin failures++; $display("FAIL single_valid_early got=%b exp=0", b4.prod_valid); end
                checks++; if (b4.busy !== 1'b1) begin failures++; $display("FAIL single_busy_mid got=%b exp=1", b4.busy); end
            end
        end
        b4.serial_in = 1'b0;
        checks++; if (b4.prod_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", b4.prod_valid); end
        checks++; if (b4.prod_data !== 8'h8F) begin failures++; $display("FAIL single_data got=%h exp=8f", b4.prod_data); end
        checks++; if (b4.busy !== 1'b0) begin failures++; $display("FAIL single_busy_done got=%b exp=0", b4.busy); end
        checks++; if (b4.overrun !== 1'b0) begin failures++; $display("FAIL single_overrun got=%b exp=0", b4.overrun); end
        step();
        checks++; if (b4.prod_valid !== 1'b1 || b4.prod_data !== 8'h8F) begin failures++; $display("FAIL single_hold got=%b/%h exp=1/8f", b4.prod_valid, b4.prod_data); end
        b4.prod_ready = 1'b1;
        step();
        b4.prod_ready = 1'b0;
        checks++; if (b4.prod_valid !== 1'b0) begin failures++; $display("FAIL single_accept got=%b exp=0", b4.prod_valid); end
    endtask

    task automatic test_back_to_back();
        run4(8'h8F, 1'b0, 1'b0);
        run4(8'h24, 1'b0, 1'b0);
        checks++; if (b4.prod_data !== 8'h24) begin failures++; $display("FAIL b2b_data got=%h exp=24", b4.prod_data); end
        checks++; if (b4.prod_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b exp=1", b4.prod_valid); end
        checks++; if (b4.overrun !== 1'b1) begin failures++; $display("FAIL b2b_overrun got=%b exp=1", b4.overrun); end
        b4.overrun_clr = 1'b1;
        step();
        b4.overrun_clr = 1'b0;
        checks++; if (b4.overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun_clr got=%b exp=0", b4.overrun); end
        checks++; if (b4.prod_valid !== 1'b1 || b4.prod_data !== 8'h24) begin failures++; $display("FAIL b2b_hold got=%b/%h exp=1/24", b4.prod_valid, b4.prod_data); end
    endtask

    task automatic test_accept_on_completion();
        accept_and_clear();
        run4(8'h8F, 1'b0, 1'b0);
        run4(8'h24, 1'b1, 1'b0);
        checks++; if (b4.prod_valid !== 1'b1) begin failures++; $display("FAIL acc_cmp_valid got=%b exp=1", b4.prod_valid); end
        checks++; if (b4.prod_data !== 8'h24) begin failures++; $display("FAIL acc_cmp_data got=%h exp=24", b4.prod_data); end
        checks++; if (b4.overrun !== 1'b0) begin failures++; $display("FAIL acc_cmp_overrun got=%b exp=0", b4.overrun); end
        accept_and_clear();
        checks++; if (b4.prod_valid !== 1'b0) begin failures++; $display("FAIL acc_cmp_drain got=%b exp=0", b4.prod_valid); end
    endtask

    task automatic test_restart();
        b4.start = 1'b1;
        step();
        b4.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b4.serial_in = 1'b1;
            step();
        end
        checks++; if (b4.busy !== 1'b1) begin failures++; $display("FAIL restart_busy got=%b exp=1", b4.busy); end
        run4(8'h3C, 1'b0, 1'b0);
        checks++; if (b4.prod_data !== 8'h3C || b4.prod_valid !== 1'b1) begin failures++; $display("FAIL restart_data got=%b/%h exp=1/3c", b4.prod_valid, b4.prod_data); end
        checks++; if (b4.overrun !== 1'b0) begin failures++; $display("FAIL restart_overrun got=%b exp=0", b4.overrun); end
    endtask

    task automatic test_start_on_completion();
        accept_and_clear();
        run4(8'h8F, 1'b0, 1'b1);
        checks++; if (b4.prod_data !== 8'h8F || b4.prod_valid !== 1'b1) begin failures++; $display("FAIL soc_data got=%b/%h exp=1/8f", b4.prod_valid, b4.prod_data); end
        checks++; if (b4.busy !== 1'b1) begin failures++; $display("FAIL soc_busy got=%b exp=1", b4.busy); end
        feed4(8'h5A, 1'b0, 1'b0);
        checks++; if (b4.prod_data !== 8'h5A) begin failures++; $display("FAIL soc_next_data got=%h exp=5a", b4.prod_data); end
        checks++; if (b4.overrun !== 1'b1) begin failures++; $display("FAIL soc_overrun got=%b exp=1", b4.overrun); end
        accept_and_clear();
    endtask

    task automatic test_rst_mid();
        logic [7:0] w;
        w = 8'h8F;
        run4(8'hA5, 1'b0, 1'b0);
        b4.start = 1'b1;
        step();
        b4.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b4.serial_in = w[i];
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        b4.serial_in = 1'b0;
        checks++; if (b4.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", b4.busy); end
        checks++; if (b4.prod_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", b4.prod_valid); end
        checks++; if (b4.prod_data !== 8'h00) begin failures++; $display("FAIL rstmid_data got=%h exp=00", b4.prod_data); end
        for (int i = 0; i < 4; i++) step();
        checks++; if (b4.prod_valid !== 1'b0) begin failures++; $display("FAIL rstmid_no_output got=%b exp=0", b4.prod_valid); end
        run4(8'hFF, 1'b0, 1'b0);
        checks++; if (b4.prod_data !== 8'hFF || b4.prod_valid !== 1'b1) begin failures++; $display("FAIL rstmid_next got=%b/%h exp=1/ff", b4.prod_valid, b4.prod_data); end
    endtask

    task automatic test_idle_start_hold();
        logic [7:0] w;
        w = 8'h5A;
        b4.start = 1'b1;
        step();
        b4.start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            b4.serial_in = w[i];
            step();
        end
        checks++; if (b4.prod_data !== 8'hFF || b4.prod_valid !== 1'b1) begin failures++; $display("FAIL hold_data got=%b/%h exp=1/ff", b4.prod_valid, b4.prod_data); end
        b4.serial_in = w[7];
        step();
        b4.serial_in = 1'b0;
        checks++; if (b4.prod_data !== 8'h5A) begin failures++; $display("FAIL hold_replace got=%h exp=5a", b4.prod_data); end
        checks++; if (b4.overrun !== 1'b1) begin failures++; $display("FAIL hold_overrun got=%b exp=1", b4.overrun); end
        accept_and_clear();
    endtask

    task automatic test_n32_random();
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
        int          bad;
        bad = 0;
        b32.prod_ready = 1'b1;
        for (int k = 0; k < 500; k++) begin
            a = $urandom;
            b = $urandom;
            p = 64'(a) * 64'(b);
            b32.start     = 1'b1;
            b32.serial_in = 1'($urandom);
            step();
            b32.start     = 1'b0;
            b32.serial_in = 1'($urandom);
            step();
            for (int i = 0; i < 64; i++) begin
                b32.serial_in = p[i];
                step();
            end
            checks++;
            if (b32.prod_data !== p || b32.prod_valid !== 1'b1) begin
                failures++;
                if (bad < 5) $display("FAIL n32_product k=%0d got=%b/%h exp=1/%h", k, b32.prod_valid, b32.prod_data, p);
                bad++;
            end
        end
        step();
        checks++; if (b32.prod_valid !== 1'b0) begin failures++; $display("FAIL n32_drain got=%b exp=0", b32.prod_valid); end
        checks++; if (b32.overrun !== 1'b0) begin failures++; $display("FAIL n32_overrun got=%b exp=0", b32.overrun); end
        b32.prod_ready = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_accept_on_completion();
        test_restart();
        test_start_on_completion();
        test_rst_mid();
        test_idle_start_hold();
        test_n32_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
